// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: source
// identities, source count, register address width and age-tag width.
package regfile_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_ALU   = 2'd0,
    SRC_MEM   = 2'd1,
    SRC_MUL   = 2'd2,
    SRC_ADDIE = 2'd3
  } src_e;

  localparam int WB_NSRC = 4;
  localparam int WB_AW   = 5;
  // An entry lives far fewer than 2**WB_TAGW acceptance cycles, so modular
  // tag distances from the running sequence counter never alias.
  localparam int WB_TAGW = 6;

  // True when tag a was issued strictly before tag b, judged by distance
  // back from the current sequence value.
  function automatic logic tag_older(input logic [WB_TAGW-1:0] seq,
                                     input logic [WB_TAGW-1:0] a,
                                     input logic [WB_TAGW-1:0] b);
    logic [WB_TAGW-1:0] age_a;
    logic [WB_TAGW-1:0] age_b;
    age_a = seq - a;
    age_b = seq - b;
    return age_a > age_b;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant: searches requests starting at the pointer, pointer
// moves to the slot after the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_ptr_upd,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_gnt_idx,
  output logic            o_gnt_vld
);

  logic [PW-1:0] r_ptr;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!o_gnt_vld && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = PW'(idx);
        o_gnt_vld  = 1'b1;
      end
    end
  end

  // Pointer holds on idle cycles, otherwise points just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_ptr_upd && o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == PW'(NREQ - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one holding register per source, age-ordered per
// destination register, round-robin among eligible entries, one registered
// write per cycle. Out-of-range destinations are dropped and flagged.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N     = 32,
  parameter int Depth = 16,
  parameter int NSRC  = WB_NSRC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       i_src_valid,
  output logic [NSRC-1:0]       o_src_ready,
  input  logic [NSRC*WB_AW-1:0] i_src_addr,
  input  logic [NSRC*N-1:0]     i_src_data,
  output logic                  o_wr_en,
  output logic [WB_AW-1:0]      o_wr_addr,
  output logic [N-1:0]          o_wr_data,
  output logic [Depth-1:0]      o_busy_mask,
  output logic                  o_addr_err,
  input  logic                  i_err_clr
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]    r_hv;
  logic [WB_AW-1:0]   r_ha [NSRC];
  logic [N-1:0]       r_hd [NSRC];
  logic [WB_TAGW-1:0] r_ht [NSRC];
  logic [WB_TAGW-1:0] r_seq;

  logic               r_wr_en;
  logic [WB_AW-1:0]   r_wr_addr;
  logic [N-1:0]       r_wr_data;
  logic               r_addr_err;

  logic [WB_AW-1:0]   w_addr [NSRC];
  logic [NSRC-1:0]    w_bad;
  logic [NSRC-1:0]    w_ready;
  logic [NSRC-1:0]    w_acc;
  logic [NSRC-1:0]    w_load;
  logic [NSRC-1:0]    w_elig;
  logic [NSRC-1:0]    w_gnt;
  logic [PW-1:0]      w_gnt_idx;
  logic               w_gnt_vld;
  logic [Depth-1:0]   w_busy;

  // Unpack per-source addresses and flag destinations beyond the file.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_addr[i] = i_src_addr[i*WB_AW +: WB_AW];
      w_bad[i]  = (32'(w_addr[i]) >= Depth);
    end
  end

  // A slot can take a new request if empty or being granted this cycle.
  assign w_ready = ~r_hv | w_gnt;
  assign w_acc   = i_src_valid & w_ready;
  assign w_load  = w_acc & ~w_bad;

  // An entry may compete only if no older entry targets the same register;
  // equal tags (same-cycle acceptance) both compete and round-robin decides.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_elig[i] = r_hv[i];
      for (int j = 0; j < NSRC; j++) begin
        if (j != i && r_hv[j] && r_ha[j] == r_ha[i] &&
            tag_older(r_seq, r_ht[j], r_ht[i])) begin
          w_elig[i] = 1'b0;
        end
      end
    end
  end

  rr_arbiter #(.NREQ(NSRC)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_elig),
    .i_ptr_upd (1'b1),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // Holding registers: load on accept (wins over a same-cycle grant), free on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv  <= '0;
      r_seq <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_ha[i] <= '0;
        r_hd[i] <= '0;
        r_ht[i] <= '0;
      end
    end else begin
      if (|w_load) r_seq <= r_seq + 1'b1;
      for (int i = 0; i < NSRC; i++) begin
        if (w_load[i]) begin
          r_hv[i] <= 1'b1;
          r_ha[i] <= w_addr[i];
          r_hd[i] <= i_src_data[i*N +: N];
          r_ht[i] <= r_seq;
        end else if (w_gnt[i]) begin
          r_hv[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage: the granted entry appears on the write port next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_wr_addr <= r_ha[w_gnt_idx];
        r_wr_data <= r_hd[w_gnt_idx];
      end
    end
  end

  // Sticky address error; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (|(w_acc & w_bad)) begin
      r_addr_err <= 1'b1;
    end else if (i_err_clr) begin
      r_addr_err <= 1'b0;
    end
  end

  // Busy bits from occupied holding registers plus the pending write.
  always_comb begin
    for (int r = 0; r < Depth; r++) begin
      w_busy[r] = r_wr_en && (r_wr_addr == WB_AW'(r));
      for (int i = 0; i < NSRC; i++) begin
        if (r_hv[i] && r_ha[i] == WB_AW'(r)) w_busy[r] = 1'b1;
      end
    end
  end

  assign o_src_ready = w_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy_mask = w_busy;
  assign o_addr_err  = r_addr_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle reference model, a table of
// one-shot request batches, directed multi-cycle sequences, random streams.
module tb_regfile_wb_arbiter;

  localparam int N     = 32;
  localparam int DEPTH = 16;
  localparam int NS    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    src_valid = '0;
  logic [3:0]    src_ready;
  logic [19:0]   src_addr = '0;
  logic [127:0]  src_data = '0;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [15:0]   busy_mask;
  logic          addr_err;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(N), .Depth(DEPTH), .NSRC(NS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_src_valid (src_valid),
    .o_src_ready (src_ready),
    .i_src_addr  (src_addr),
    .i_src_data  (src_data),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy_mask (busy_mask),
    .o_addr_err  (addr_err),
    .i_err_clr   (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t obs_q[$];

  // Reference model: pending requests with integer arrival stamps.
  bit          m_v [4];
  int          m_a [4];
  logic [31:0] m_d [4];
  int          m_s [4];
  int          m_ptr;
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  int          cyc;

  always @(negedge clk) begin : mon
    int g;
    int a;
    bit newerr;
    bit elig [4];
    logic [3:0]  e_rdy;
    logic [15:0] e_busy;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      m_ptr = 0; m_wen = 0; m_err = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      // An entry waits if another pending one for the same register arrived earlier.
      for (int i = 0; i < 4; i++) begin
        elig[i] = m_v[i];
        for (int j = 0; j < 4; j++)
          if (j != i && m_v[j] && m_a[j] == m_a[i] && m_s[j] < m_s[i]) elig[i] = 0;
      end
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && elig[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      for (int i = 0; i < 4; i++) e_rdy[i] = !m_v[i] || (g == i);
      e_busy = '0;
      for (int i = 0; i < 4; i++) if (m_v[i]) e_busy[m_a[i]] = 1'b1;
      if (m_wen) e_busy[m_waddr] = 1'b1;

      chk("ready", src_ready, e_rdy);
      chk("wr_en", wr_en, m_wen);
      if (m_wen) begin
        chk("wr_addr", wr_addr, m_waddr);
        chk("wr_data", wr_data, m_wdata);
      end
      chk("busy_mask", busy_mask, e_busy);
      chk("addr_err", addr_err, m_err);
      if (wr_en) obs_q.push_back({wr_addr, wr_data});

      m_wen = (g >= 0);
      if (g >= 0) begin
        m_waddr = m_a[g];
        m_wdata = m_d[g];
        m_v[g]  = 0;
        m_ptr   = (g + 1) % 4;
      end
      newerr = 0;
      for (int i = 0; i < 4; i++) begin
        if (src_valid[i] && e_rdy[i]) begin
          a = int'(src_addr[i*5 +: 5]);
          if (a >= DEPTH) newerr = 1;
          else begin
            m_v[i] = 1; m_a[i] = a; m_d[i] = src_data[i*32 +: 32]; m_s[i] = cyc;
          end
        end
      end
      if (newerr) m_err = 1;
      else if (err_clr) m_err = 0;
      cyc++;
    end
  end

  typedef struct packed {
    logic [3:0]        vld;
    logic [3:0][4:0]   addr;
    logic [3:0][31:0]  data;
    logic [2:0]        n;
    logic [3:0][1:0]   order;
    logic              err;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int n, input int o0, input int o1,
                              input int o2, input int o3, input logic e);
    vec_t r;
    r.vld = v;
    r.addr[0] = a0; r.addr[1] = a1; r.addr[2] = a2; r.addr[3] = a3;
    r.data[0] = d0; r.data[1] = d1; r.data[2] = d2; r.data[3] = d3;
    r.n = 3'(n);
    r.order[0] = 2'(o0); r.order[1] = 2'(o1); r.order[2] = 2'(o2); r.order[3] = 2'(o3);
    r.err = e;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    src_valid = '0;
    err_clr   = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
    src_valid[i]       = 1'b1;
    src_addr[i*5 +: 5] = a;
    src_data[i*32 +: 32] = d;
  endtask

  // Sources hold each request until accepted; returns write-count/checksum deltas.
  task automatic run_stream(input int ncyc, input int pct, output int stall,
                            output int nsent, output logic [63:0] sum_sent);
    bit          pv [4];
    logic [4:0]  pa [4];
    logic [31:0] pd [4];
    logic [3:0]  acc;
    stall = 0; nsent = 0; sum_sent = 0;
    for (int i = 0; i < 4; i++) pv[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < pct) begin
          pv[i] = 1;
          pa[i] = 5'($urandom_range(0, 17));
          pd[i] = $urandom;
        end
        if (pv[i]) set_src(i, pa[i], pd[i]);
        else src_valid[i] = 1'b0;
      end
      err_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      acc = src_valid & src_ready;
      if (src_valid[0] && !src_ready[0]) stall++;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          if (pa[i] < 5'(DEPTH)) begin
            nsent++;
            sum_sent += 64'(pd[i]);
          end
          pv[i] = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    idle(12);
  endtask

  vec_t vecs [10];
  int   stall, nsent, nwr, i11, i22;
  logic [63:0] sum_s, sum_w;

  initial begin
    vecs[0] = mk(4'b1111, 1, 2, 3, 4, 32'h101, 32'h102, 32'h103, 32'h104, 4, 0, 1, 2, 3, 0);
    vecs[1] = mk(4'b0001, 3, 0, 0, 0, 32'hAA, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[2] = mk(4'b1111, 1, 2, 3, 4, 32'h201, 32'h202, 32'h203, 32'h204, 4, 1, 2, 3, 0, 0);
    vecs[3] = mk(4'b0110, 0, 9, 9, 0, 0, 32'h301, 32'h302, 0, 2, 1, 2, 0, 0, 0);
    vecs[4] = mk(4'b1001, 12, 0, 0, 12, 32'h400, 0, 0, 32'h403, 2, 3, 0, 0, 0, 0);
    vecs[5] = mk(4'b0100, 0, 0, 20, 0, 0, 0, 32'h502, 0, 0, 0, 0, 0, 0, 1);
    vecs[6] = mk(4'b1111, 20, 5, 17, 6, 32'h600, 32'h601, 32'h602, 32'h603, 2, 1, 3, 0, 0, 1);
    vecs[7] = mk(4'b1000, 0, 0, 0, 15, 0, 0, 0, 32'h7F, 1, 3, 0, 0, 0, 0);
    vecs[8] = mk(4'b0010, 0, 16, 0, 0, 0, 32'h801, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[9] = mk(4'b0001, 0, 0, 0, 0, 32'h900, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", src_ready, 4'hF);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_err", addr_err, 0);
    step();

    // One-shot batches into an empty arbiter.
    for (int t = 0; t < 10; t++) begin
      obs_q.delete();
      src_valid = '0;
      for (int i = 0; i < 4; i++)
        if (vecs[t].vld[i]) set_src(i, vecs[t].addr[i], vecs[t].data[i]);
      step();
      src_valid = '0;
      repeat (8) step();
      chk($sformatf("v%0d_nwrites", t), obs_q.size(), vecs[t].n);
      for (int k = 0; k < int'(vecs[t].n) && k < obs_q.size(); k++) begin
        chk($sformatf("v%0d_w%0d_addr", t, k), obs_q[k].a, vecs[t].addr[vecs[t].order[k]]);
        chk($sformatf("v%0d_w%0d_data", t, k), obs_q[k].d, vecs[t].data[vecs[t].order[k]]);
      end
      chk($sformatf("v%0d_err", t), addr_err, vecs[t].err);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
    end

    // Latency and busy window of a lone ALU write.
    idle(2);
    set_src(0, 5'd3, 32'h0000_00AA);
    @(negedge clk);
    chk("lat_c0_wr_en", wr_en, 0);
    @(posedge clk); #1 src_valid = '0;
    @(negedge clk);
    chk("lat_c1_wr_en", wr_en, 0);
    chk("lat_c1_busy3", busy_mask[3], 1);
    @(negedge clk);
    chk("lat_c2_wr_en", wr_en, 1);
    chk("lat_c2_addr", wr_addr, 3);
    chk("lat_c2_data", wr_data, 32'hAA);
    chk("lat_c2_busy3", busy_mask[3], 1);
    @(negedge clk);
    chk("lat_c3_wr_en", wr_en, 0);
    chk("lat_c3_busy3", busy_mask[3], 0);
    step();

    // Same destination: earlier-accepted MEM write must precede ALU even
    // when the pointer favours ALU.
    idle(2);
    set_src(1, 5'd6, 32'h66);
    step();
    idle(6);
    obs_q.delete();
    set_src(1, 5'd5, 32'h11);
    set_src(2, 5'd8, 32'h88);
    set_src(3, 5'd9, 32'h99);
    step();
    src_valid = '0;
    set_src(0, 5'd5, 32'h22);
    step();
    idle(8);
    chk("age_nwrites", obs_q.size(), 4);
    i11 = -1; i22 = -1;
    foreach (obs_q[k]) begin
      if (obs_q[k].d == 32'h11) i11 = k;
      if (obs_q[k].d == 32'h22) i22 = k;
    end
    chk("age_11_before_22", (i11 >= 0 && i22 > i11), 1);
    if (obs_q.size() == 4) begin
      chk("age_w0", obs_q[0].d, 32'h88);
      chk("age_w1", obs_q[1].d, 32'h99);
      chk("age_w2", obs_q[2].d, 32'h11);
      chk("age_w3", obs_q[3].d, 32'h22);
    end

    // Out-of-range destination: dropped, sticky until cleared.
    obs_q.delete();
    set_src(2, 5'd20, 32'hDEAD);
    step();
    idle(5);
    chk("err_no_write", obs_q.size(), 0);
    chk("err_sticky", addr_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", addr_err, 0);
    set_src(2, 5'd20, 32'hBEEF);
    err_clr = 1'b1;
    step();
    src_valid = '0;
    err_clr = 1'b0;
    chk("err_beats_clr", addr_err, 1);
    idle(2);
    chk("err_beats_clr_hold", addr_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // All sources requesting continuously: ALU must see backpressure.
    obs_q.delete();
    run_stream(24, 100, stall, nsent, sum_s);
    sum_w = 0;
    foreach (obs_q[k]) sum_w += 64'(obs_q[k].d);
    chk("hold_alu_stalled", (stall > 0), 1);
    chk("hold_count", obs_q.size(), nsent);
    chk("hold_sum", sum_w, sum_s);

    // Random traffic against the model.
    obs_q.delete();
    run_stream(3000, 55, stall, nsent, sum_s);
    sum_w = 0;
    foreach (obs_q[k]) sum_w += 64'(obs_q[k].d);
    chk("rand_count", obs_q.size(), nsent);
    chk("rand_sum", sum_w, sum_s);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Reset with three occupied entries: nothing may be written afterwards.
    idle(2);
    set_src(0, 5'd1, 32'hA1);
    set_src(1, 5'd2, 32'hA2);
    set_src(2, 5'd3, 32'hA3);
    step();
    src_valid = '0;
    @(negedge clk);
    chk("rstmid_busy_pre", busy_mask, 16'h000E);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete();
    chk("rstmid_ready", src_ready, 4'hF);
    chk("rstmid_busy", busy_mask, 0);
    idle(6);
    chk("rstmid_no_write", obs_q.size(), 0);
    chk("rstmid_ready_after", src_ready, 4'hF);
    chk("rstmid_busy_after", busy_mask, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N, default 32: register data width.
REQ-002 SHALL have parameter Depth, default 16: register count; registers addressed 0..Depth-1.
REQ-003 SHALL have parameter NSRC, default 4: writeback requesters (0=ALU, 1=MEM, 2=MUL, 3=ADDIE).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port src_valid  input  NSRC  per-source write request.
REQ-007 SHALL have port src_ready  output  NSRC  per-source accept; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have port src_addr  input  NSRC*5  per-source destination register.
REQ-009 SHALL have port src_data  input  NSRC*N  per-source write data.
REQ-010 SHALL have port wr_en  output  1  register-file write strobe.
REQ-011 SHALL have port wr_addr  output  5  register-file write address.
REQ-012 SHALL have port wr_data  output  N  register-file write data.
REQ-013 SHALL have port busy_mask  output  Depth  bit r high while any buffered write targets register r.
REQ-014 SHALL have port addr_err  output  1  sticky flag: an accepted request had addr >= Depth.
REQ-015 SHALL have port err_clr  input  1  synchronous clear of addr_err.

Function
REQ-016 SHALL hold one holding register (valid, addr, data) per source.
REQ-017 SHALL drive src_ready[i] high when holding register i is empty, or will be emptied by a grant in the same cycle.
REQ-018 SHALL run a per-cycle round-robin grant among occupied holding registers.
REQ-019 SHALL give the pointer priority after the last granted source.
REQ-020 SHALL leave the pointer unchanged on cycles with no grant.
REQ-021 SHALL register the granted entry onto wr_en/wr_addr/wr_data one cycle after the grant.
REQ-022 SHALL give a write latency of 2 cycles from accept to wr_en, with no contention.
REQ-023 SHALL sustain throughput of one write per cycle.
REQ-024 SHALL, for two occupied entries with the same addr, grant the one accepted earlier first.
REQ-025 SHALL track acceptance age with a per-entry sequence tag.
REQ-026 SHALL break same-cycle acceptance ties by round-robin order.
REQ-027 SHALL, when an accepted addr >= Depth: drop the entry without a write; set addr_err; not stall.
REQ-028 SHALL compute busy_mask combinationally from occupied holding registers plus the output stage.
REQ-029 SHALL clear the busy_mask bit in the cycle after wr_en for that register, unless another entry still targets it.
REQ-030 SHALL, with simultaneous err_clr and a new error, leave addr_err at 1.
REQ-031 SHALL pass wr_data unmodified; it performs no width conversion.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear all holding-register valid bits.
REQ-033 SHALL, on rst_n low, clear wr_en, wr_addr, wr_data, busy_mask, addr_err and the round-robin pointer (pointer to source 0).
REQ-034 SHALL drive src_ready to all-ones after reset.
REQ-035 SHALL discard writes in flight when reset asserts mid-operation; no partial write is issued after release.

Structure
REQ-036 SHALL take from a shared package: the source enum (ALU, MEM, MUL, ADDIE), NSRC, the address width of 5, and the sequence-tag width.
REQ-037 SHALL instantiate one sub-module, rr_arbiter: a parameterised round-robin grant with request, grant and pointer-update ports.

Verification
REQ-038 SHALL cover: a single ALU request addr=3, data=0x0000_00AA -> wr_en exactly 2 cycles later with wr_addr=3, data 0xAA; busy_mask[3] high for 2 cycles.
REQ-039 SHALL cover: all four sources valid in one cycle with addrs 1,2,3,4 -> four consecutive writes in order 0,1,2,3; then, with all four valid again, order 1,2,3,0.
REQ-040 SHALL cover: MEM accepts addr=5, data=0x11; one cycle later ALU accepts addr=5, data=0x22 -> 0x11 is written before 0x22.
REQ-041 SHALL cover: MUL addr=20 -> no wr_en; addr_err=1 until err_clr.
REQ-042 SHALL cover: MUL addr=20 with err_clr high in the same cycle -> addr_err stays 1.
REQ-043 SHALL cover: ALU valid continuously while its grant is pending -> src_ready[0] low until the grant; no request is lost or duplicated.
REQ-044 SHALL cover: rst_n pulsed low with three entries occupied -> no wr_en after release; busy_mask=0; src_ready all ones.
